// File: rtl/memnode_pkg.sv
// ============================================================================
// Module  : memnode_pkg
// Brief   : Shared state encoding and bank geometry for the memnode arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package memnode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    localparam int              MEM_IDX_W    = 6;
    localparam int              MEM_WORD_W   = 16;
    localparam logic [MEM_IDX_W-1:0] MEM_LAST_IDX = 6'd63;

endpackage

`default_nettype wire

// File: rtl/memnode_rr_arb.sv
// ============================================================================
// Module  : memnode_rr_arb
// Brief   : Combinational round-robin pick: first request at or after last+1.
// Revision: 1.0
// ============================================================================
`default_nettype none

module memnode_rr_arb #(
    parameter int N_REQ = 2,
    parameter int SEL_W = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [SEL_W-1:0] i_last,
    output logic [N_REQ-1:0] o_grant,
    output logic [SEL_W-1:0] o_winner,
    output logic             o_valid
);

    int w_idx;

    always_comb begin
        o_grant  = '0;
        o_winner = '0;
        o_valid  = 1'b0;
        w_idx    = 0;
        // Scan starts one past the previous winner so it ends up lowest priority.
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = (int'(i_last) + k) % N_REQ;
            if (!o_valid && i_req[w_idx]) begin
                o_valid        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_winner       = SEL_W'(w_idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/memnode_arbiter.sv
// ============================================================================
// Module  : memnode_arbiter
// Brief   : Round-robin arbiter sharing one 64x8 word-access bank between
//           N_REQ requesters. Define MEMNODE_ALIGN_CHK_EN to reject odd indices.
// Revision: 1.0
// ============================================================================
`default_nettype none

module memnode_arbiter
    import memnode_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int IDX_W  = 6,
    parameter int WORD_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        we,
    input  logic [N_REQ*IDX_W-1:0]  addr,
    input  logic [N_REQ*WORD_W-1:0] wdata,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        err,
    output logic [WORD_W-1:0]       rdata,
    output logic                    busy,
    output logic                    mem_wr_en,
    output logic [IDX_W-1:0]        mem_index,
    output logic [WORD_W-1:0]       mem_data_in,
    input  logic [WORD_W-1:0]       mem_data_out
);

    localparam int SEL_W = $clog2(N_REQ);

    state_t             r_state;
    state_t             w_next;
    logic [SEL_W-1:0]   r_last;
    logic [N_REQ-1:0]   r_grant;
    logic               r_we;
    logic [IDX_W-1:0]   r_addr;
    logic [WORD_W-1:0]  r_wdata;
    logic [WORD_W-1:0]  r_rdata;

    logic [N_REQ-1:0]   w_grant;
    logic [SEL_W-1:0]   w_winner;
    logic               w_valid;
    logic               w_reject;

    memnode_rr_arb #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_rr_arb (
        .i_req    (req),
        .i_last   (r_last),
        .o_grant  (w_grant),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    // The top index cannot host a 16-bit word: its second byte is off the bank.
`ifdef MEMNODE_ALIGN_CHK_EN
    assign w_reject = (r_addr == IDX_W'(MEM_LAST_IDX)) || r_addr[0];
`else
    assign w_reject = (r_addr == IDX_W'(MEM_LAST_IDX));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_last  <= SEL_W'(N_REQ - 1);
            r_grant <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_valid) begin
                r_last  <= w_winner;
                r_grant <= w_grant;
                r_we    <= we[w_winner];
                r_addr  <= addr[w_winner*IDX_W +: IDX_W];
                r_wdata <= wdata[w_winner*WORD_W +: WORD_W];
            end
            if (r_state == ST_ISSUE && !r_we && !w_reject) begin
                r_rdata <= mem_data_out;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        ack         = '0;
        err         = '0;
        mem_wr_en   = 1'b0;
        mem_index   = '0;
        mem_data_in = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_wr_en   = r_we && !w_reject;
                mem_index   = r_addr;
                mem_data_in = r_wdata;
                w_next      = ST_ACK;
            end
            ST_ACK: begin
                ack    = r_grant;
                err    = w_reject ? r_grant : '0;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign busy  = (r_state != ST_IDLE);
    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_memnode_arbiter.sv
// ============================================================================
// Module  : tb_memnode_arbiter
// Brief   : Directed self-checking bench with a behavioural 64x8 bank model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_memnode_arbiter;

    localparam int N  = 2;
    localparam int IW = 6;
    localparam int WW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*IW-1:0] addr;
    logic [N*WW-1:0] wdata;
    logic [N-1:0]    ack;
    logic [N-1:0]    err;
    logic [WW-1:0]   rdata;
    logic            busy;
    logic            mem_wr_en;
    logic [IW-1:0]   mem_index;
    logic [WW-1:0]   mem_data_in;
    logic [WW-1:0]   mem_data_out;

    logic [7:0]      bank [64];
    logic            bank_init;
    int              wr_cnt = 0;

    int n_checks = 0;
    int n_errors = 0;

    memnode_arbiter #(
        .N_REQ  (N),
        .IDX_W  (IW),
        .WORD_W (WW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .ack          (ack),
        .err          (err),
        .rdata        (rdata),
        .busy         (busy),
        .mem_wr_en    (mem_wr_en),
        .mem_index    (mem_index),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    // Big-endian word view of the byte bank: high byte at index, low at index+1.
    assign mem_data_out = {bank[mem_index], bank[mem_index + 6'd1]};

    always @(posedge clk) begin
        if (bank_init) begin
            for (int i = 0; i < 64; i++) bank[i] <= 8'(i);
        end else if (mem_wr_en) begin
            bank[mem_index]         <= mem_data_in[15:8];
            bank[mem_index + 6'd1]  <= mem_data_in[7:0];
        end
    end

    always @(negedge clk) begin
        if (mem_wr_en) wr_cnt <= wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic access(input int r, input bit w, input logic [5:0] a, input logic [15:0] d,
                          output bit got_ack, output int lat,
                          output logic [N-1:0] ack_v, output logic [N-1:0] err_v,
                          output logic [15:0] rd);
        req[r]            = 1'b1;
        we[r]             = w;
        addr[r*IW +: IW]  = a;
        wdata[r*WW +: WW] = d;
        lat     = 1;
        got_ack = 1'b0;
        ack_v   = '0;
        err_v   = '0;
        rd      = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            lat++;
            if (ack != '0) begin
                got_ack = 1'b1;
                ack_v   = ack;
                err_v   = err;
                rd      = rdata;
                break;
            end
        end
        req[r] = 1'b0;
        @(posedge clk); #1;
    endtask

    bit           g_ack;
    int           g_lat;
    logic [N-1:0] g_ackv;
    logic [N-1:0] g_errv;
    logic [15:0]  g_rd;
    int           wr_base;

    initial begin
        rst       = 1'b1;
        bank_init = 1'b1;
        req       = '0;
        we        = '0;
        addr      = '0;
        wdata     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",   32'(ack),         32'h0);
        check("rst_err",   32'(err),         32'h0);
        check("rst_rdata", 32'(rdata),       32'h0);
        check("rst_busy",  32'(busy),        32'h0);
        check("rst_wren",  32'(mem_wr_en),   32'h0);
        check("rst_index", 32'(mem_index),   32'h0);
        check("rst_din",   32'(mem_data_in), 32'h0);
        rst       = 1'b0;
        bank_init = 1'b0;
        @(posedge clk); #1;

        // Write then read back by requester 0.
        access(0, 1'b1, 6'd10, 16'hA55A, g_ack, g_lat, g_ackv, g_errv, g_rd);
        check("wr10_ack",  32'(g_ack),  32'h1);
        check("wr10_ackv", 32'(g_ackv), 32'h1);
        check("wr10_err",  32'(g_errv), 32'h0);
        check("wr10_lat",  32'(g_lat),  32'd3);
        check("wr10_b10",  32'(bank[10]), 32'hA5);
        check("wr10_b11",  32'(bank[11]), 32'h5A);
        access(0, 1'b0, 6'd10, 16'h0000, g_ack, g_lat, g_ackv, g_errv, g_rd);
        check("rd10_ackv", 32'(g_ackv), 32'h1);
        check("rd10_lat",  32'(g_lat),  32'd3);
        check("rd10_data", 32'(g_rd),   32'hA55A);

        // Out-of-range index rejected without touching the bank.
        wr_base = wr_cnt;
        access(1, 1'b1, 6'd63, 16'hFFFF, g_ack, g_lat, g_ackv, g_errv, g_rd);
        check("rej_ackv",  32'(g_ackv), 32'h2);
        check("rej_errv",  32'(g_errv), 32'h2);
        check("rej_wren",  32'(wr_cnt - wr_base), 32'h0);
        check("rej_b62",   32'(bank[62]), 32'h3E);
        check("rej_b63",   32'(bank[63]), 32'h3F);
        check("rej_rdata", 32'(g_rd),   32'hA55A);

        // Odd index: legal unless alignment checking is built in.
        access(0, 1'b1, 6'd5, 16'h1234, g_ack, g_lat, g_ackv, g_errv, g_rd);
        check("odd_ackv", 32'(g_ackv), 32'h1);
`ifdef MEMNODE_ALIGN_CHK_EN
        check("odd_err", 32'(g_errv),  32'h1);
        check("odd_b5",  32'(bank[5]), 32'h05);
        check("odd_b6",  32'(bank[6]), 32'h06);
`else
        check("odd_err", 32'(g_errv),  32'h0);
        check("odd_b5",  32'(bank[5]), 32'h12);
        check("odd_b6",  32'(bank[6]), 32'h34);
`endif

        // Reset asserted while the write is in ISSUE.
        req[0]         = 1'b1;
        we[0]          = 1'b1;
        addr[0 +: IW]  = 6'd20;
        wdata[0 +: WW] = 16'hBEEF;
        @(posedge clk); #1;
        check("rsti_busy", 32'(busy),      32'h1);
        check("rsti_wren", 32'(mem_wr_en), 32'h1);
        rst    = 1'b1;
        req[0] = 1'b0;
        @(posedge clk); #1;
        check("rsti_ack",   32'(ack),       32'h0);
        check("rsti_err",   32'(err),       32'h0);
        check("rsti_busy0", 32'(busy),      32'h0);
        check("rsti_wren0", 32'(mem_wr_en), 32'h0);
        check("rsti_index", 32'(mem_index), 32'h0);
        check("rsti_rdata", 32'(rdata),     32'h0);
        check("rsti_b20",   32'(bank[20]),  32'hBE);
        check("rsti_b21",   32'(bank[21]),  32'hEF);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rsti_ack2",  32'(ack),       32'h0);

        // Both requesters held high: strict alternation starting at 0.
        we             = '0;
        addr[0 +: IW]  = 6'd10;
        addr[IW +: IW] = 6'd20;
        req            = 2'b11;
        for (int k = 0; k < 4; k++) begin
            g_ack = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                if (ack != '0) begin
                    g_ack = 1'b1;
                    break;
                end
            end
            check("arb_seen", 32'(g_ack), 32'h1);
            check("arb_ack",  32'(ack),   (k % 2 == 0) ? 32'h1 : 32'h2);
            check("arb_data", 32'(rdata), (k % 2 == 0) ? 32'hA55A : 32'hBEEF);
        end
        req = '0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memnode_arbiter.md
Name: memnode_arbiter

Overview:
- Shares one memorybankNode instance (64 x 8-bit bytes, 16-bit big-endian word access at index/index+1) between N_REQ requesters.
- Requesters are the Q-value updater, the neighbour-table writer and the packet/energy logger.
- Round-robin arbitration, one outstanding access at a time, req/ack handshake per requester.
- Guards the bank against out-of-range word accesses.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- IDX_W, 6, byte index width into the bank.
- WORD_W, 16, word width.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request, held high until ack sampled.
- we  in  N_REQ  per-requester write (1) / read (0) qualifier, valid with req.
- addr  in  N_REQ*IDX_W  flattened byte indices, slot i at [i*IDX_W +: IDX_W].
- wdata  in  N_REQ*WORD_W  flattened write words.
- ack  out  N_REQ  one-hot, one-cycle completion pulse.
- err  out  N_REQ  one-hot, one-cycle pulse coincident with ack when the access was rejected.
- rdata  out  WORD_W  read word, valid in the ack cycle.
- busy  out  1  high in ISSUE and ACK.
- mem_wr_en  out  1  to bank wr_en.
- mem_index  out  IDX_W  to bank index.
- mem_data_in  out  WORD_W  to bank data_in.
- mem_data_out  in  WORD_W  from bank data_out (combinational read).

Behaviour:
- Reset values: state=IDLE, ack=0, err=0, rdata=0, busy=0, mem_wr_en=0, mem_index=0, mem_data_in=0, rr pointer last=N_REQ-1, so requester 0 wins first.
- IDLE:
  - If any req is high, pick the winner as the first requester at or after (last+1) mod N_REQ.
  - Latch the winner's we, addr and wdata; update last=winner; go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE (1 cycle):
  - mem_index=latched addr, mem_data_in=latched wdata.
  - mem_wr_en = latched we AND NOT reject.
  - On the closing edge, the write commits in the bank, or rdata <= mem_data_out for a read. Go to ACK.
- ACK (1 cycle):
  - ack[winner]=1. err[winner]=reject.
  - rdata holds the read word, or is unchanged for writes and rejects.
  - Go to IDLE.
- Requester handshake: the requester drops req on the edge where it samples ack. A req still high in the following IDLE cycle is a new request.
- Access latency is 3 cycles, req rise to ack pulse inclusive. Peak throughput is 1 access per 3 cycles.
- Reject rule: addr==63 is rejected, because index+1 falls outside the bank. A rejected access does no write, leaves rdata unchanged, and still acks with err=1.
- Requester inputs may change while not granted. Latched values are immune to changes during ISSUE/ACK.
- Simultaneous requests: strict round-robin. A requester that just won has lowest priority next time; no starvation.
- Reset mid-operation:
  - A reset asserted in ISSUE does not block the write committing on that edge, since mem_wr_en was already high.
  - No ack or err is produced for that access, and the FSM returns to IDLE.
- mem_* outputs are 0 in IDLE and ACK. This avoids spurious writes.

Optional Feature:
- Macro MEMNODE_ALIGN_CHK_EN.
- Defined: odd addresses are also rejected (err=1, no write, rdata unchanged). This enforces word alignment on even byte boundaries.
- Undefined: odd addresses 1..61 are legal unaligned word accesses; only addr==63 is rejected.

Decomposition:
- Shared package memnode_pkg holds:
  - state encoding: IDLE=2'd0, ISSUE=2'd1, ACK=2'd2;
  - MEM_IDX_W=6, MEM_WORD_W=16, MEM_LAST_IDX=63.
- One sub-module, memnode_rr_arb: combinational round-robin pick from req and last. It outputs a one-hot grant and the winner index.

Test Plan:
- Single write then read by req0, addr=10, wdata=16'hA55A, then read addr=10 -> ack[0] at cycle 3 each; rdata=16'hA55A; bank bytes [10]=8'hA5, [11]=8'h5A.
- Both requesters held high continuously, four accesses -> grants alternate 0,1,0,1; no back-to-back repeat.
- req1 writes addr=63, wdata=16'hFFFF -> ack[1]=err[1]=1; mem_wr_en never high; bank bytes [62],[63] unchanged.
- Odd address write addr=5, wdata=16'h1234 -> with macro: err=1, bank unchanged; without macro: bytes [5]=8'h12, [6]=8'h34, err=0.
- Reset during ISSUE of a write to addr=20, 16'hBEEF -> bank holds 16'hBEEF at 20/21; no ack; outputs return to reset values; next request served from IDLE with requester 0 first.
